control_contadores_transicion: RTL

Synchronous controller that shares one transition-counter memory (NUM_CNT words of W_CNT bits) between NUM_CNT adder power monitors.
- Arbitrates increment requests round-robin and performs a read-modify-write per grant.
- Clears the memory automatically after reset and on command.
- Serves single-word readout to the bench/host.
- Replaces direct bench-driven dir/LE/dato sequencing of the counter memory.

---
 rtl/control_contadores_transicion_pkg.sv | 22 ++
 rtl/control_contadores_transicion_arbitro_rr.sv | 29 ++
 rtl/control_contadores_transicion.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/control_contadores_transicion_pkg.sv
// Shared types and constants for the transition-counter controller:
// FSM state encoding, memory LE polarity and default widths.
package paquete_contadores;

  localparam int NUM_CNT_DEF = 3;
  localparam int NDIR_DEF    = 2;
  localparam int W_INC_DEF   = 8;
  localparam int W_CNT_DEF   = 32;

  localparam logic LE_LEER     = 1'b1;
  localparam logic LE_ESCRIBIR = 1'b0;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_CLEAR,
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RDOUT
  } estado_t;

endpackage

// File: rtl/control_contadores_transicion_arbitro_rr.sv
// Combinational round-robin arbiter: grants the first set request at or
// after ptr, wrapping modulo NUM_CNT. The pointer register lives in the caller.
module arbitro_rr #(
  parameter int NUM_CNT = 3,
  parameter int NDIR    = 2
) (
  input  logic [NUM_CNT-1:0] req,
  input  logic [NDIR-1:0]    ptr,
  output logic               gnt_vld,
  output logic [NDIR-1:0]    gnt_idx
);

  logic [NDIR-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = NUM_CNT - 1; k >= 0; k--) begin
      idx = NDIR'((int'(ptr) + k) % NUM_CNT);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/control_contadores_transicion.sv
// Shared transition-counter memory controller: post-reset/commanded clear,
// round-robin read-modify-write increments with saturation, single-word readout.
module control_contadores_transicion
  import paquete_contadores::*;
#(
  parameter int NUM_CNT = NUM_CNT_DEF,
  parameter int NDIR    = NDIR_DEF,
  parameter int W_INC   = W_INC_DEF,
  parameter int W_CNT   = W_CNT_DEF
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic [NUM_CNT-1:0]       req,
  input  logic [NUM_CNT*W_INC-1:0] inc,
  output logic [NUM_CNT-1:0]       ack,
  input  logic                     clr,
  input  logic                     rd_req,
  input  logic [NDIR-1:0]          rd_dir,
  output logic [W_CNT-1:0]         rd_dato,
  output logic                     rd_valid,
  output logic                     busy,
  output logic [NDIR-1:0]          mem_dir,
  output logic                     mem_le,
  output logic [W_CNT-1:0]         mem_wdata,
  input  logic [W_CNT-1:0]         mem_rdata
);

  localparam logic [NDIR-1:0] ULT_DIR   = NDIR'(NUM_CNT - 1);
  localparam logic [NDIR:0]   NUM_CNT_W = (NDIR + 1)'(NUM_CNT);

  logic [NUM_CNT-1:0][W_INC-1:0] inc_v;
  assign inc_v = inc;

  estado_t              st_q, st_d;
  logic [NDIR-1:0]      clr_ptr_q, clr_ptr_d;
  logic [NDIR-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NDIR-1:0]      g_q, g_d;
  logic [NDIR-1:0]      rd_dir_q, rd_dir_d;
  logic [W_CNT-1:0]     hold_q, hold_d;
  logic [W_CNT-1:0]     rd_dato_q, rd_dato_d;
  logic                 clr_pend_q, clr_pend_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [NUM_CNT-1:0]   ack_q, ack_d;

  logic                 gnt_vld;
  logic [NDIR-1:0]      gnt_idx;
  logic [W_CNT:0]       suma;
  logic [W_CNT-1:0]     wdata_sat;

  arbitro_rr #(.NUM_CNT(NUM_CNT), .NDIR(NDIR)) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // One extra bit catches the carry so the counter sticks at all-ones.
  always_comb begin
    suma      = {1'b0, hold_q} + {{(W_CNT + 1 - W_INC){1'b0}}, inc_v[g_q]};
    wdata_sat = suma[W_CNT] ? '1 : suma[W_CNT-1:0];
  end

  always_comb begin
    busy      = (st_q != ST_IDLE);
    mem_le    = LE_LEER;
    mem_dir   = '0;
    mem_wdata = '0;
    case (st_q)
      ST_CLEAR: begin
        mem_le  = LE_ESCRIBIR;
        mem_dir = clr_ptr_q;
      end
      ST_READ:  mem_dir = g_q;
      ST_WRITE: begin
        mem_le    = LE_ESCRIBIR;
        mem_dir   = g_q;
        mem_wdata = wdata_sat;
      end
      ST_RDOUT: mem_dir = rd_dir_q;
      default: ;
    endcase
  end

  always_comb begin
    st_d       = st_q;
    clr_ptr_d  = clr_ptr_q;
    rr_ptr_d   = rr_ptr_q;
    g_d        = g_q;
    rd_dir_d   = rd_dir_q;
    hold_d     = hold_q;
    rd_dato_d  = rd_dato_q;
    ack_d      = '0;
    rd_valid_d = 1'b0;
    // A clear arriving mid-operation waits until we are back in IDLE.
    clr_pend_d = clr_pend_q | (clr && (st_q != ST_IDLE));
    case (st_q)
      ST_INIT: st_d = ST_CLEAR;
      ST_CLEAR: begin
        if (clr_ptr_q == ULT_DIR) begin
          clr_ptr_d = '0;
          st_d      = ST_IDLE;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr || clr_pend_q) begin
          clr_pend_d = 1'b0;
          st_d       = ST_CLEAR;
        end else if (rd_req) begin
          rd_dir_d = rd_dir;
          st_d     = ST_RDOUT;
        end else if (gnt_vld) begin
          g_d  = gnt_idx;
          st_d = ST_READ;
        end
      end
      ST_READ: begin
        hold_d = mem_rdata;
        st_d   = ST_WRITE;
      end
      ST_WRITE: begin
        ack_d[g_q] = 1'b1;
        rr_ptr_d   = (g_q == ULT_DIR) ? '0 : g_q + 1'b1;
        st_d       = ST_IDLE;
      end
      ST_RDOUT: begin
        rd_dato_d  = ({1'b0, rd_dir_q} >= NUM_CNT_W) ? '0 : mem_rdata;
        rd_valid_d = 1'b1;
        st_d       = ST_IDLE;
      end
      default: st_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      st_q       <= ST_INIT;
      clr_ptr_q  <= '0;
      rr_ptr_q   <= '0;
      g_q        <= '0;
      rd_dir_q   <= '0;
      hold_q     <= '0;
      rd_dato_q  <= '0;
      clr_pend_q <= 1'b0;
      rd_valid_q <= 1'b0;
      ack_q      <= '0;
    end else begin
      st_q       <= st_d;
      clr_ptr_q  <= clr_ptr_d;
      rr_ptr_q   <= rr_ptr_d;
      g_q        <= g_d;
      rd_dir_q   <= rd_dir_d;
      hold_q     <= hold_d;
      rd_dato_q  <= rd_dato_d;
      clr_pend_q <= clr_pend_d;
      rd_valid_q <= rd_valid_d;
      ack_q      <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign rd_valid = rd_valid_q;
  assign rd_dato  = rd_dato_q;

endmodule
